// File: rtl/count_uart_pkg.sv
// Shared types and constants for the counter UART transmitter.
// Optional even parity is enabled with COUNT_UART_TX_PARITY_EN.
package count_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic TX_IDLE   = 1'b1;

endpackage

// File: rtl/count_uart_tx_if.sv
// Valid/ready byte handshake between the counter and the UART transmitter.
// The counter side is the master, the transmitter the slave.
interface count_uart_tx_if;
  import count_uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/count_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high.
// tick pulses on the terminal count; clear restarts a full period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_uart_tx.sv
// Serialises the counter byte as an 8N1 UART frame on a registered tx pin.
// Define COUNT_UART_TX_PARITY_EN to insert an even-parity bit before stop.
module count_uart_tx
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  count_uart_tx_if.slave   in_if,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 tick;
  logic                 accept;
  logic                 last_stop;
  logic                 last_bit;
`ifdef COUNT_UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign in_if.in_ready = (state_q == IDLE);
  assign accept    = in_if.in_valid && in_if.in_ready;
  assign last_stop = (STOP_BITS == 1) || stop_q;
  assign last_bit  = (idx_q == LAST_IDX);
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (tick) state_d = DATA;
      DATA: begin
        if (tick && last_bit) begin
`ifdef COUNT_UART_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef COUNT_UART_TX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`else
      PARITY: state_d = IDLE;
`endif
      STOP: if (tick && last_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // tx_d anticipates the bit that starts on the next cycle
  always_comb begin
    frame_done = (state_q == STOP) && tick && last_stop;
    tx_d       = tx_q;
    unique case (1'b1)
      accept:
        tx_d = 1'b0;
      (state_q == START) && tick:
        tx_d = shift_q[0];
      (state_q == DATA) && tick && !last_bit:
        tx_d = shift_q[1];
`ifdef COUNT_UART_TX_PARITY_EN
      (state_q == DATA) && tick && last_bit:
        tx_d = par_q;
      (state_q == PARITY) && tick:
        tx_d = TX_IDLE;
`else
      (state_q == DATA) && tick && last_bit:
        tx_d = TX_IDLE;
`endif
      default:
        tx_d = tx_q;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    if (accept) begin
      shift_d = in_if.in_data;
      idx_d   = '0;
      stop_d  = 1'b0;
    end else if (tick && state_q == DATA) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + 1'b1;
    end else if (tick && state_q == STOP) begin
      stop_d  = !last_stop;
    end
  end

`ifdef COUNT_UART_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (accept) begin
      par_d = ^in_if.in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      tx_q    <= TX_IDLE;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1.
// Build with COUNT_UART_TX_PARITY_EN to cover the parity frame.
module tb_count_uart_tx;

  localparam int CPB = 4;
`ifdef COUNT_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + P;
  localparam int L  = NB * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx, busy, frame_done;

  count_uart_tx_if u_if ();

  count_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_if     (u_if),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [63:0] txv, fdv;
  int busy_bad;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [11:0] bits;
    logic [63:0] w;
    bits = '0;
    w = '0;
    bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) bits[k+1] = b[k];
    if (P == 1) bits[9] = ^b;
    bits[NB-1] = 1'b1;
    for (int i = 0; i < L; i++) w[i] = bits[i/CPB];
    return w;
  endfunction

  function automatic logic [7:0] decode(input logic [63:0] w);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = w[CPB*(k+1) + CPB/2];
    return d;
  endfunction

  // Enter at the negedge before the accepting edge; leave at cycle 1.
  task automatic start(input logic [7:0] b, input bit hold);
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.in_data  = b;
    chk("ready_before", u_if.in_ready, 1'b1);
    @(negedge clk);
    if (!hold) u_if.in_valid = 1'b0;
    u_if.in_data = ~b;
  endtask

  // Samples cycles 1..L, then checks the idle cycle L+1.
  task automatic frame(input string tag, input logic [7:0] b,
                       input int poke);
    txv = '0;
    fdv = '0;
    busy_bad = 0;
    for (int i = 0; i < L; i++) begin
      txv[i] = tx;
      fdv[i] = frame_done;
      if (busy !== 1'b1) busy_bad++;
      if (i == poke) begin
        u_if.in_valid = 1'b1;
        u_if.in_data  = 8'h55;
      end
      if (i == poke + 1) u_if.in_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_wave"}, txv, exp_wave(b));
    chk({tag, "_byte"}, 64'(decode(txv)), 64'(b));
    chk({tag, "_done"}, fdv, 64'd1 << (L - 1));
    chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
`ifdef COUNT_UART_TX_PARITY_EN
    chk({tag, "_par"}, 64'(txv[CPB*9 + 2]), 64'(^b));
`endif
    chk({tag, "_gap_tx"}, 64'(tx), 64'd1);
    chk({tag, "_gap_rdy"}, 64'(u_if.in_ready), 64'd1);
    chk({tag, "_gap_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int nb;
    nb = 0;
    for (int i = 0; i < n; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0 ||
          u_if.in_ready !== 1'b1 || frame_done !== 1'b0)
        nb++;
      @(negedge clk);
    end
    chk(tag, 64'(nb), 64'd0);
  endtask

  initial begin
    int fd_cnt;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_rdy", 64'(u_if.in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    rst_n = 1'b1;
    idle_watch("idle20", 20);

    start(8'hA5, 1'b0);
    frame("a5", 8'hA5, 1000);

    start(8'h00, 1'b1);
    u_if.in_data = 8'hFF;
    frame("b2b0", 8'h00, 1000);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    frame("b2b1", 8'hFF, 1000);

    start(8'h96, 1'b0);
    frame("ign", 8'h96, 10);
    idle_watch("ign_idle", 8);

    start(8'h3C, 1'b0);
    repeat (17) @(negedge clk);
    chk("mid_bit3", 64'(tx), 64'd1);
    chk("mid_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tx", 64'(tx), 64'd1);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_rdy", 64'(u_if.in_ready), 64'd1);
    fd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (frame_done !== 1'b0) fd_cnt++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (frame_done !== 1'b0) fd_cnt++;
      @(negedge clk);
    end
    chk("abort_nodone", 64'(fd_cnt), 64'd0);
    start(8'h81, 1'b0);
    frame("post81", 8'h81, 1000);

`ifdef COUNT_UART_TX_PARITY_EN
    start(8'h07, 1'b0);
    frame("p07", 8'h07, 1000);
    chk("p07_bit", 64'(txv[CPB*9 + 1]), 64'd1);
    start(8'h03, 1'b0);
    frame("p03", 8'h03, 1000);
    chk("p03_bit", 64'(txv[CPB*9 + 1]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
